// File: rtl/retire_tracker.sv
// Retire tracking pipe: carries PC/valid through ID/EX/MEM/WB for debug
// retirement outputs and saturating performance counters.
module retire_tracker #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [PC_W-1:0]  i_if_pc,
  input  logic             i_if_vld,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_ex_ctrl,
  input  logic             i_ex_mispred,
  input  logic             i_cnt_clr,
  output logic [PC_W-1:0]  o_pc_debug,
  output logic             o_insn_vld,
  output logic             o_ctrl,
  output logic             o_mispred,
  output logic [CNT_W-1:0] o_cnt_cycle,
  output logic [CNT_W-1:0] o_cnt_insn,
  output logic [CNT_W-1:0] o_cnt_ctrl,
  output logic [CNT_W-1:0] o_cnt_mispred
);

  logic [PC_W-1:0]  id_pc_q, id_pc_d;
  logic             id_vld_q, id_vld_d;
  logic [PC_W-1:0]  ex_pc_q, ex_pc_d;
  logic             ex_vld_q, ex_vld_d;
  logic [PC_W-1:0]  mem_pc_q, mem_pc_d;
  logic             mem_vld_q, mem_vld_d;
  logic             mem_ctrl_q, mem_ctrl_d;
  logic             mem_mis_q, mem_mis_d;
  logic [PC_W-1:0]  wb_pc_q, wb_pc_d;
  logic             wb_vld_q, wb_vld_d;
  logic             wb_ctrl_q, wb_ctrl_d;
  logic             wb_mis_q, wb_mis_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] insn_q, insn_d;
  logic [CNT_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0] mis_q, mis_d;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    if (en && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  always_comb begin
    id_pc_d  = id_pc_q;
    id_vld_d = id_vld_q;
    if (i_flush) begin
      id_vld_d = 1'b0;
    end else if (!i_stall) begin
      id_pc_d  = i_if_pc;
      id_vld_d = i_if_vld;
    end

    ex_pc_d  = id_pc_q;
    ex_vld_d = id_vld_q & ~(i_flush | i_stall);

    // the flushing EX instruction itself advances with its tags
    mem_pc_d   = ex_pc_q;
    mem_vld_d  = ex_vld_q;
    mem_ctrl_d = ex_vld_q & i_ex_ctrl;
    mem_mis_d  = mem_ctrl_d & i_ex_mispred;

    // debug PC keeps the last retired PC across bubbles
    wb_pc_d   = mem_vld_q ? mem_pc_q : wb_pc_q;
    wb_vld_d  = mem_vld_q;
    wb_ctrl_d = mem_ctrl_q;
    wb_mis_d  = mem_mis_q;

    if (i_cnt_clr) begin
      cyc_d  = '0;
      insn_d = '0;
      ctrl_d = '0;
      mis_d  = '0;
    end else begin
      cyc_d  = sat_inc(cyc_q, 1'b1);
      insn_d = sat_inc(insn_q, wb_vld_q);
      ctrl_d = sat_inc(ctrl_q, wb_ctrl_q);
      mis_d  = sat_inc(mis_q, wb_mis_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      id_pc_q    <= '0;
      id_vld_q   <= 1'b0;
      ex_pc_q    <= '0;
      ex_vld_q   <= 1'b0;
      mem_pc_q   <= '0;
      mem_vld_q  <= 1'b0;
      mem_ctrl_q <= 1'b0;
      mem_mis_q  <= 1'b0;
      wb_pc_q    <= '0;
      wb_vld_q   <= 1'b0;
      wb_ctrl_q  <= 1'b0;
      wb_mis_q   <= 1'b0;
      cyc_q      <= '0;
      insn_q     <= '0;
      ctrl_q     <= '0;
      mis_q      <= '0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_vld_q   <= id_vld_d;
      ex_pc_q    <= ex_pc_d;
      ex_vld_q   <= ex_vld_d;
      mem_pc_q   <= mem_pc_d;
      mem_vld_q  <= mem_vld_d;
      mem_ctrl_q <= mem_ctrl_d;
      mem_mis_q  <= mem_mis_d;
      wb_pc_q    <= wb_pc_d;
      wb_vld_q   <= wb_vld_d;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_mis_q   <= wb_mis_d;
      cyc_q      <= cyc_d;
      insn_q     <= insn_d;
      ctrl_q     <= ctrl_d;
      mis_q      <= mis_d;
    end
  end

  assign o_pc_debug    = wb_pc_q;
  assign o_insn_vld    = wb_vld_q;
  assign o_ctrl        = wb_ctrl_q;
  assign o_mispred     = wb_mis_q;
  assign o_cnt_cycle   = cyc_q;
  assign o_cnt_insn    = insn_q;
  assign o_cnt_ctrl    = ctrl_q;
  assign o_cnt_mispred = mis_q;

endmodule

// File: tb/tb_retire_tracker.sv
// Bench for retire_tracker: directed steps plus random traffic, checked
// against an instruction-record model with per-record stage ages.
module tb_retire_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_vld, stall, flush, ex_ctrl, ex_mis, clr;
  logic [31:0] if_pc;

  logic [31:0] pc_dbg, c_cyc, c_insn, c_ctrl, c_mis;
  logic        vld, ctrl, mis;
  logic [31:0] pc4;
  logic        vld4, ctrl4, mis4;
  logic [3:0]  k_cyc, k_insn, k_ctrl, k_mis;

  retire_tracker #(.PC_W(32), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_if_pc(if_pc), .i_if_vld(if_vld),
    .i_stall(stall), .i_flush(flush), .i_ex_ctrl(ex_ctrl),
    .i_ex_mispred(ex_mis), .i_cnt_clr(clr),
    .o_pc_debug(pc_dbg), .o_insn_vld(vld), .o_ctrl(ctrl),
    .o_mispred(mis), .o_cnt_cycle(c_cyc), .o_cnt_insn(c_insn),
    .o_cnt_ctrl(c_ctrl), .o_cnt_mispred(c_mis)
  );

  retire_tracker #(.PC_W(32), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_if_pc(if_pc), .i_if_vld(if_vld),
    .i_stall(stall), .i_flush(flush), .i_ex_ctrl(ex_ctrl),
    .i_ex_mispred(ex_mis), .i_cnt_clr(clr),
    .o_pc_debug(pc4), .o_insn_vld(vld4), .o_ctrl(ctrl4),
    .o_mispred(mis4), .o_cnt_cycle(k_cyc), .o_cnt_insn(k_insn),
    .o_cnt_ctrl(k_ctrl), .o_cnt_mispred(k_mis)
  );

  int checks = 0;
  int errors = 0;

  // stage: 0=ID 1=EX 2=MEM 3=WB
  typedef struct {
    int          stage;
    logic [31:0] pc;
    bit          c;
    bit          m;
  } rec_t;

  rec_t q[$];
  longint unsigned r_cyc, r_insn, r_ctrl, r_mis;
  logic [31:0] disp_pc;

  function automatic longint unsigned sat(longint unsigned v, int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int wb_idx();
    foreach (q[i]) if (q[i].stage == 3) return i;
    return -1;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    rec_t nq[$];
    rec_t r;
    int w;
    w = wb_idx();
    if (rst) begin
      q.delete();
      r_cyc = 0; r_insn = 0; r_ctrl = 0; r_mis = 0;
      disp_pc = '0;
      return;
    end
    if (clr) begin
      r_cyc = 0; r_insn = 0; r_ctrl = 0; r_mis = 0;
    end else begin
      r_cyc++;
      if (w >= 0) begin
        r_insn++;
        if (q[w].c) r_ctrl++;
        if (q[w].m) r_mis++;
      end
    end
    foreach (q[i]) begin
      r = q[i];
      if (r.stage == 2) begin
        r.stage = 3;
        disp_pc = r.pc;
        nq.push_back(r);
      end else if (r.stage == 1) begin
        r.c = ex_ctrl;
        r.m = ex_ctrl && ex_mis;
        r.stage = 2;
        nq.push_back(r);
      end else if (r.stage == 0 && !flush) begin
        if (!stall) r.stage = 1;
        nq.push_back(r);
      end
    end
    if (!flush && !stall && if_vld) begin
      r.stage = 0; r.pc = if_pc; r.c = 0; r.m = 0;
      nq.push_back(r);
    end
    q = nq;
  endtask

  task automatic check_all();
    int w;
    bit ev, ec, em;
    w = wb_idx();
    ev = (w >= 0);
    ec = ev && q[w].c;
    em = ev && q[w].m;
    chk("vld", {63'd0, vld}, {63'd0, ev});
    chk("ctrl", {63'd0, ctrl}, {63'd0, ec});
    chk("mispred", {63'd0, mis}, {63'd0, em});
    chk("pc", {32'd0, pc_dbg}, {32'd0, disp_pc});
    chk("cnt_cycle", {32'd0, c_cyc}, sat(r_cyc, 32));
    chk("cnt_insn", {32'd0, c_insn}, sat(r_insn, 32));
    chk("cnt_ctrl", {32'd0, c_ctrl}, sat(r_ctrl, 32));
    chk("cnt_mispred", {32'd0, c_mis}, sat(r_mis, 32));
    chk("w4_vld", {63'd0, vld4}, {63'd0, ev});
    chk("w4_pc", {32'd0, pc4}, {32'd0, disp_pc});
    chk("w4_ctrl", {63'd0, ctrl4}, {63'd0, ec});
    chk("w4_mispred", {63'd0, mis4}, {63'd0, em});
    chk("w4_cnt_cycle", {60'd0, k_cyc}, sat(r_cyc, 4));
    chk("w4_cnt_insn", {60'd0, k_insn}, sat(r_insn, 4));
    chk("w4_cnt_ctrl", {60'd0, k_ctrl}, sat(r_ctrl, 4));
    chk("w4_cnt_mispred", {60'd0, k_mis}, sat(r_mis, 4));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 0; if_vld = 0; if_pc = '0; stall = 0;
    flush = 0; ex_ctrl = 0; ex_mis = 0; clr = 0;
  endtask

  task automatic feed(logic [31:0] pc);
    if_vld = 1; if_pc = pc;
    tick();
  endtask

  initial begin
    idle();
    q.delete();
    r_cyc = 0; r_insn = 0; r_ctrl = 0; r_mis = 0;
    disp_pc = '0;

    // reset held with IF valid
    rst = 1; if_vld = 1; if_pc = 32'h100;
    repeat (3) tick();
    chk("rst_vld", {63'd0, vld}, 64'd0);
    chk("rst_cyc", {32'd0, c_cyc}, 64'd0);

    // back-to-back 0x0,0x4,0x8
    idle();
    feed(32'h0); feed(32'h4); feed(32'h8);
    idle();
    repeat (4) tick();
    chk("t2_insn", {32'd0, c_insn}, 64'd3);

    // one stall cycle while 0x8 sits in ID
    feed(32'h0); feed(32'h4); feed(32'h8);
    stall = 1; feed(32'hC);
    stall = 0; feed(32'hC);
    idle();
    repeat (6) tick();

    // mispredicted branch at 0x10 flushes 0x14/0x18
    feed(32'h10); feed(32'h14);
    flush = 1; ex_ctrl = 1; ex_mis = 1;
    feed(32'h18);
    idle();
    feed(32'h40);
    idle();
    repeat (6) tick();
    chk("t4_ctrl", {32'd0, c_ctrl}, 64'd1);
    chk("t4_mispred", {32'd0, c_mis}, 64'd1);

    // mispred without ctrl, then saturation at width 4
    feed(32'h20); feed(32'h24);
    ex_mis = 1; feed(32'h28);
    idle();
    repeat (5) tick();
    clr = 1; tick();
    idle();
    for (int i = 0; i < 20; i++) feed(32'h200 + 32'(i * 4));
    idle();
    repeat (6) tick();
    chk("t5_insn4", {60'd0, k_insn}, 64'd15);
    chk("t5_insn32", {32'd0, c_insn}, 64'd20);
    clr = 1; tick();
    idle();
    chk("t5_clr_cyc", {32'd0, c_cyc}, 64'd0);

    // reset with three instructions in flight
    feed(32'h300); feed(32'h304); feed(32'h308);
    idle();
    rst = 1; tick();
    rst = 0;
    repeat (6) tick();
    chk("t6_insn", {32'd0, c_insn}, 64'd0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      rst     = ($urandom_range(49) == 0);
      clr     = ($urandom_range(39) == 0);
      if_vld  = ($urandom_range(3) != 0);
      if_pc   = {$urandom_range(32'h3FFF), 2'b00};
      stall   = ($urandom_range(5) == 0);
      flush   = ($urandom_range(7) == 0);
      ex_ctrl = ($urandom_range(2) == 0);
      ex_mis  = ($urandom_range(1) == 0);
      tick();
    end
    idle();
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
